video_tx: RTL and testbench

Pixel-stream-to-video transmitter: the sending end of the byte-serial DVD/DVSYN/DHSYN interface that the capture path consumes. Takes full-width pixels (DVD_CHN channels of DVD_DW bits) over a valid/ready handshake and emits them one channel byte per clock, framed by field (DVSYN) and line-valid (DHSYN) strobes, with programmable blanking. Used as the video source in loopback benches and as the output stage feeding downstream capture blocks.

---
 rtl/video_tx.sv | 209 ++++++++++++++++++++
 tb/tb_video_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_tx.sv
// Byte-serial video transmitter: one-pixel holding register feeding a channel serializer,
// framed by DVSYN/DHSYN with programmable blanking. Optional test pattern: VIDEO_TX_PATTERN_EN.
module video_tx #(
    parameter int IW      = 640,
    parameter int IH      = 512,
    parameter int DVD_DW  = 8,
    parameter int DVD_CHN = 3,
    parameter int HB      = 16,
    parameter int VB      = 64
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      EN,
    input  logic                      PAT_SEL,
    input  logic [DVD_DW*DVD_CHN-1:0] PIX_DAT,
    input  logic                      PIX_DVALID,
    output logic                      PIX_RDY,
    output logic [DVD_DW-1:0]         DVD,
    output logic                      DVSYN,
    output logic                      DHSYN,
    output logic                      FRAME_DONE,
    output logic                      UNDERFLOW
);
    localparam int PW   = DVD_DW * DVD_CHN;
    localparam int BMAX = (HB > VB) ? HB : VB;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int XW   = (IW > 1) ? $clog2(IW) : 1;
    localparam int YW   = (IH > 1) ? $clog2(IH) : 1;
    localparam int CW   = (DVD_CHN > 1) ? $clog2(DVD_CHN) : 1;

    localparam logic [BW-1:0] HB_LAST = BW'(HB - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(VB - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IW - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IH - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(DVD_CHN - 1);

    typedef enum logic [2:0] {S_IDLE, S_VLEAD, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CW-1:0]     byte_q, byte_d;
    logic [PW-1:0]     sreg_q, sreg_d;
    logic [PW-1:0]     hold_q, hold_d;
    logic              empty_q, empty_d;
    logic              uf_q, uf_d;
    logic [DVD_DW-1:0] dvd_q, dvd_d;
    logic              dvsyn_q, dvsyn_d;
    logic              dhsyn_q, dhsyn_d;
    logic              done_q, done_d;

    logic              slot;
    logic              use_pat;
    logic [PW-1:0]     src;
    logic [PW-1:0]     pat;
    logic [DVD_DW-1:0] cur_byte;

`ifdef VIDEO_TX_PATTERN_EN
    logic [DVD_DW-1:0] px, py;
    always_comb begin
        px  = DVD_DW'(x_q);
        py  = DVD_DW'(y_q);
        pat = '0;
        for (int c = 0; c < DVD_CHN; c++) begin
            if (c == DVD_CHN - 1)      pat[c*DVD_DW +: DVD_DW] = px;
            else if (c == DVD_CHN - 2) pat[c*DVD_DW +: DVD_DW] = py;
            else                       pat[c*DVD_DW +: DVD_DW] = px ^ py;
        end
    end
    assign use_pat = PAT_SEL;
`else
    logic unused_pat_sel;
    assign unused_pat_sel = PAT_SEL;
    assign pat            = '0;
    assign use_pat        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        x_d      = x_q;
        y_d      = y_q;
        byte_d   = byte_q;
        sreg_d   = sreg_q;
        hold_d   = hold_q;
        empty_d  = empty_q;
        uf_d     = uf_q;
        cur_byte = '0;

        slot = (state_q == S_ACTIVE) && (byte_q == '0);
        src  = use_pat ? pat : (empty_q ? '0 : hold_q);

        // Holding register: the slot drains it only when full, a load only fills it when empty.
        if (PIX_DVALID && empty_q) begin
            hold_d  = PIX_DAT;
            empty_d = 1'b0;
        end
        if (slot) begin
            if (!use_pat) begin
                if (!empty_q) empty_d = 1'b1;
                else          uf_d    = 1'b1;
            end
            sreg_d   = src << DVD_DW;
            cur_byte = src[PW-1 -: DVD_DW];
        end else if (state_q == S_ACTIVE) begin
            sreg_d   = sreg_q << DVD_DW;
            cur_byte = sreg_q[PW-1 -: DVD_DW];
        end

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_VLEAD;
                    blk_d   = '0;
                end
            end
            S_VLEAD: begin
                if (blk_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    blk_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    byte_d  = '0;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            S_ACTIVE: begin
                if (byte_q == C_LAST) begin
                    byte_d = '0;
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        blk_d   = '0;
                        state_d = (y_q == Y_LAST) ? S_VBLANK : S_HBLANK;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
            S_HBLANK: begin
                if (blk_q == HB_LAST) begin
                    state_d = S_ACTIVE;
                    blk_d   = '0;
                    y_d     = y_q + 1'b1;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            S_VBLANK: begin
                if (blk_q == VB_LAST) begin
                    blk_d   = '0;
                    y_d     = '0;
                    state_d = EN ? S_VLEAD : S_IDLE;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes follow the state one cycle later, keeping every output a flop.
        dvsyn_d = (state_q == S_VLEAD) || (state_q == S_ACTIVE) || (state_q == S_HBLANK);
        dhsyn_d = (state_q == S_ACTIVE);
        dvd_d   = dhsyn_d ? cur_byte : '0;
        done_d  = (state_q == S_VBLANK) && (blk_q == VB_LAST);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            byte_q  <= '0;
            sreg_q  <= '0;
            hold_q  <= '0;
            empty_q <= 1'b1;
            uf_q    <= 1'b0;
            dvd_q   <= '0;
            dvsyn_q <= 1'b0;
            dhsyn_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            x_q     <= x_d;
            y_q     <= y_d;
            byte_q  <= byte_d;
            sreg_q  <= sreg_d;
            hold_q  <= hold_d;
            empty_q <= empty_d;
            uf_q    <= uf_d;
            dvd_q   <= dvd_d;
            dvsyn_q <= dvsyn_d;
            dhsyn_q <= dhsyn_d;
            done_q  <= done_d;
        end
    end

    assign PIX_RDY    = empty_q;
    assign DVD        = dvd_q;
    assign DVSYN      = dvsyn_q;
    assign DHSYN      = dhsyn_q;
    assign FRAME_DONE = done_q;
    assign UNDERFLOW  = uf_q;
endmodule

// File: tb/tb_video_tx.sv
// Bench for video_tx: small frame geometry, queue-based pixel model and frame timing checks.
module tb_video_tx;
    localparam int IW = 4, IH = 2, DW = 8, CHN = 3, HB = 2, VB = 3;
    localparam int NB = IW * IH * CHN;
    localparam int BURST = IW * CHN;
    localparam int VS_HIGH = HB + IH * IW * CHN + (IH - 1) * HB;

    logic          CLOCK = 0;
    logic          RESET = 1;
    logic          EN = 0;
    logic          PAT_SEL = 0;
    logic [23:0]   PIX_DAT = '0;
    logic          PIX_DVALID = 0;
    logic          PIX_RDY;
    logic [7:0]    DVD;
    logic          DVSYN, DHSYN, FRAME_DONE, UNDERFLOW;

    video_tx #(.IW(IW), .IH(IH), .DVD_DW(DW), .DVD_CHN(CHN), .HB(HB), .VB(VB)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .EN(EN), .PAT_SEL(PAT_SEL),
        .PIX_DAT(PIX_DAT), .PIX_DVALID(PIX_DVALID), .PIX_RDY(PIX_RDY),
        .DVD(DVD), .DVSYN(DVSYN), .DHSYN(DHSYN),
        .FRAME_DONE(FRAME_DONE), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0, errors = 0;
    int cyc = 0;
    int mode = 3;
    int frames_done = 0, n_acc = 0;
    int vs_len = 0, rise_gap = 0, bursts = 0;
    logic acc_last = 0;
    logic [7:0] fb [NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rnd_pix();
        return {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
    endfunction

    initial forever begin
        @(posedge CLOCK);
        cyc++;
    end

    // Pixel source: 0 always valid, 1 random valid (held until taken), 3 idle.
    initial forever begin
        @(posedge CLOCK);
        #1;
        case (mode)
            0: begin
                if (acc_last || !PIX_DVALID) PIX_DAT = rnd_pix();
                PIX_DVALID = 1'b1;
            end
            1: begin
                if (!(PIX_DVALID && !acc_last)) begin
                    PIX_DVALID = 1'($urandom_range(0, 1));
                    PIX_DAT    = rnd_pix();
                end
            end
            default: PIX_DVALID = 1'b0;
        endcase
    end

    // Reference model: accepted pixels queue up; a slot takes the oldest pixel that
    // reached the register before the slot, otherwise emits zeros and flags underflow.
    initial begin
        logic [23:0] acc_q[$];
        int          acc_t[$];
        logic [23:0] exp_pix;
        logic [7:0]  xx, yy;
        logic        exp_uf, vs_prev, dh_prev, pat_on;
        int          bi, burst, vs_run, low_run, k, sl;
        exp_uf = 0; vs_prev = 0; dh_prev = 0; exp_pix = '0;
        bi = 0; burst = 0; vs_run = 0; low_run = 0;
        forever begin
            @(negedge CLOCK);
            if (RESET) begin
                acc_q.delete(); acc_t.delete();
                exp_uf = 0; vs_prev = 0; dh_prev = 0;
                bi = 0; burst = 0; vs_run = 0; low_run = 0; bursts = 0;
                acc_last = 0;
            end else begin
`ifdef VIDEO_TX_PATTERN_EN
                pat_on = PAT_SEL;
`else
                pat_on = 1'b0;
`endif
                acc_last = PIX_DVALID && PIX_RDY;
                if (acc_last) begin
                    acc_q.push_back(PIX_DAT);
                    acc_t.push_back(cyc);
                    n_acc++;
                end
                if (DVSYN && !vs_prev) begin
                    rise_gap = low_run; vs_run = 0; bursts = 0; bi = 0;
                end
                if (DHSYN) begin
                    k  = bi % CHN;
                    sl = bi / CHN;
                    if (k == 0) begin
                        if (pat_on) begin
                            xx = 8'(sl % IW);
                            yy = 8'(sl / IW);
                            exp_pix = {xx, yy, xx ^ yy};
                        end else if (acc_q.size() > 0 && acc_t[0] <= cyc - 2) begin
                            exp_pix = acc_q.pop_front();
                            void'(acc_t.pop_front());
                        end else begin
                            exp_pix = '0;
                            exp_uf  = 1'b1;
                        end
                    end
                    check("dvd_byte", DVD, exp_pix[23 - 8*k -: 8]);
                    if (bi < NB) fb[bi] = DVD;
                    bi++; burst++;
                end else begin
                    check("dvd_blank", DVD, 0);
                end
                if (!DHSYN && dh_prev) begin
                    check("burst_len", burst, BURST);
                    burst = 0; bursts++;
                end
                if (DVSYN) vs_run++;
                if (!DVSYN && vs_prev) vs_len = vs_run;
                if (!DVSYN) low_run++; else low_run = 0;
                if (FRAME_DONE) begin
                    check("done_pos", low_run, VB);
                    frames_done++;
                end
                check("underflow", UNDERFLOW, exp_uf);
                vs_prev = DVSYN; dh_prev = DHSYN;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLOCK); #1 RESET = 1;
        cycles(2);
        RESET = 0;
    endtask

    task automatic pulse_en();
        @(posedge CLOCK); #1 EN = 1;
        @(posedge CLOCK); #1 EN = 0;
    endtask

    task automatic wait_done(input int max);
        int s;
        s = frames_done;
        for (int i = 0; i < max && frames_done == s; i++) @(negedge CLOCK);
        check("timeout_done", 32'(frames_done != s), 1);
    endtask

    initial begin
        int n0;
        int got;
        cycles(3);
        check("rst_dvd", DVD, 0);
        check("rst_dvsyn", DVSYN, 0);
        check("rst_dhsyn", DHSYN, 0);
        check("rst_done", FRAME_DONE, 0);
        check("rst_uf", UNDERFLOW, 0);
        check("rst_rdy", PIX_RDY, 1);
        RESET = 0;

        // Single frame, pixels always valid
        mode = 0;
        cycles(4);
        n0 = n_acc;
        pulse_en();
        wait_done(200);
        check("f1_vs_len", vs_len, VS_HIGH);
        check("f1_bursts", bursts, IH);
        check("f1_accepts", n_acc - n0, IW * IH);
        check("f1_uf", UNDERFLOW, 0);
        cycles(10);
        check("f1_idle", DVSYN, 0);

        // Back-to-back frames
        EN = 1;
        wait_done(200);
        wait_done(200);
        check("b2b_gap", rise_gap, VB);
        check("b2b_vs_len", vs_len, VS_HIGH);
        EN = 0;
        wait_done(200);
        check("b2b_uf", UNDERFLOW, 0);
        cycles(5);

        // Starve the second pixel slot of line 0
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLOCK);
            got = int'(!PIX_RDY);
        end
        check("uf_preload", got, 1);
        mode = 3;
        pulse_en();
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLOCK);
            got = int'(DHSYN);
        end
        check("uf_dhsyn_seen", got, 1);
        @(posedge CLOCK);
        @(posedge CLOCK);
        mode = 0;
        wait_done(200);
        check("uf_b3", fb[3], 0);
        check("uf_b4", fb[4], 0);
        check("uf_b5", fb[5], 0);
        check("uf_b6_nz", 32'(fb[6] != 0), 1);
        check("uf_set", UNDERFLOW, 1);
        pulse_en();
        wait_done(200);
        check("uf_sticky", UNDERFLOW, 1);

        // Random pixel availability across several frames
        mode = 1;
        EN = 1;
        repeat (3) wait_done(200);
        EN = 0;
        wait_done(200);
        mode = 0;

        // Reset in the middle of line 1
        do_reset();
        cycles(3);
        pulse_en();
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLOCK);
            got = int'(bursts == 1 && DHSYN);
        end
        check("mr_line1_seen", got, 1);
        repeat (4) @(negedge CLOCK);
        @(posedge CLOCK); #1 RESET = 1;
        @(posedge CLOCK); #1;
        check("mr_dvsyn", DVSYN, 0);
        check("mr_dhsyn", DHSYN, 0);
        check("mr_dvd", DVD, 0);
        check("mr_rdy", PIX_RDY, 1);
        RESET = 0;
        cycles(8);
        check("mr_no_resume", DVSYN, 0);
        pulse_en();
        wait_done(200);
        check("mr_vs_len", vs_len, VS_HIGH);
        check("mr_bursts", bursts, IH);
        check("mr_uf", UNDERFLOW, 0);

        // Pattern select
        PAT_SEL = 1;
        cycles(4);
        pulse_en();
        wait_done(200);
`ifdef VIDEO_TX_PATTERN_EN
        check("pat_b18", fb[18], 8'h02);
        check("pat_b19", fb[19], 8'h01);
        check("pat_b20", fb[20], 8'h03);
        check("pat_rdy", PIX_RDY, 0);
`endif
        check("pat_uf", UNDERFLOW, 0);
        PAT_SEL = 0;
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
